// File: rtl/systolic_ctrl_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared state encoding and sizing helpers for the systolic sequencer.
// Revision : 1.0
// ============================================================================
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPUTE = 3'd1,
        DRAIN   = 3'd2,
        HOLD    = 3'd3,
        DISPLAY = 3'd4
    } ctrl_state_e;

    // All-ones address of the given width marks an empty (NULL) slot.
    function automatic logic [31:0] null_addr(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r = r + 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_ctrl_param_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl_param_if
// Brief    : Board-control inputs and array/memory address outputs of the sequencer.
// Revision : 1.0
// ============================================================================
interface systolic_ctrl_param_if #(
    parameter int ADDR_W = 5,
    parameter int BUF_AW = 2
);
    logic              start;
    logic              toggle;
    logic              right;
    logic              left;
    logic [ADDR_W-1:0] input_side_addr;
    logic [ADDR_W-1:0] input_ceiling_addr;
    logic [ADDR_W-1:0] filter_ceiling_addr;
    logic [ADDR_W-1:0] filter_side_addr;
    logic              sys_en;
    logic [BUF_AW-1:0] buffer_read_addr;
    logic              busy;
    logic              done;

    modport master (
        output start, toggle, right, left,
        input  input_side_addr, input_ceiling_addr, filter_ceiling_addr,
               filter_side_addr, sys_en, buffer_read_addr, busy, done
    );

    modport slave (
        input  start, toggle, right, left,
        output input_side_addr, input_ceiling_addr, filter_ceiling_addr,
               filter_side_addr, sys_en, buffer_read_addr, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/systolic_ctrl_param_btn_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge_det
// Brief    : One-cycle pulse on the rising edge of a button level.
// Revision : 1.0
// ============================================================================
module btn_edge_det (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_btn,
    output logic      o_pulse
);
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) r_prev <= 1'b0;
        else     r_prev <= i_btn;
    end

    assign o_pulse = i_btn & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/systolic_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl_param
// Brief    : Streams input/filter addresses into the systolic array, drains it,
//            then holds and lets the buttons walk the result buffer.
// Revision : 1.0
// ============================================================================
module systolic_ctrl_param
    import ctrl_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int STREAM_LEN   = 12,
    parameter int CEIL_OFFSET  = 4,
    parameter int GROUP        = 4,
    parameter int FILT_BASE    = 24,
    parameter int DRAIN_CYCLES = 1,
    parameter int NUM_OUT      = 4
) (
    input wire logic            clk,
    input wire logic            rst,
    systolic_ctrl_param_if.slave bus
);
    localparam int BUF_AW  = clog2(NUM_OUT);
    localparam int SLOT_W  = (clog2(GROUP) < 1) ? 1 : clog2(GROUP);
    localparam int CNT_MAX = (STREAM_LEN > DRAIN_CYCLES) ? STREAM_LEN : DRAIN_CYCLES;
    localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);

    localparam logic [2:0] c_ST_IDLE    = IDLE;
    localparam logic [2:0] c_ST_COMPUTE = COMPUTE;
    localparam logic [2:0] c_ST_DRAIN   = DRAIN;
    localparam logic [2:0] c_ST_HOLD    = HOLD;
    localparam logic [2:0] c_ST_DISPLAY = DISPLAY;

    localparam logic [ADDR_W-1:0] c_NULL        = ADDR_W'(null_addr(ADDR_W));
    localparam logic [ADDR_W-1:0] c_FILT_BASE   = ADDR_W'(FILT_BASE);
    localparam logic [ADDR_W-1:0] c_CEIL_OFF    = ADDR_W'(CEIL_OFFSET);
    localparam logic [CNT_W-1:0]  c_STREAM_LAST = CNT_W'(STREAM_LEN - 1);
    localparam logic [CNT_W-1:0]  c_DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [SLOT_W-1:0] c_SLOT_LAST   = SLOT_W'(GROUP - 1);
    localparam logic [BUF_AW-1:0] c_BUF_LAST    = BUF_AW'(NUM_OUT - 1);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SLOT_W-1:0] r_slot;
    logic [ADDR_W-1:0] r_faddr;
    logic [ADDR_W-1:0] r_side;
    logic [ADDR_W-1:0] r_iceil;
    logic [ADDR_W-1:0] r_fceil;
    logic [ADDR_W-1:0] r_fside;
    logic              r_sys_en;
    logic [BUF_AW-1:0] r_buf_addr;
    logic              r_busy;
    logic              r_done;

    logic              w_right_edge;
    logic              w_left_edge;
    logic [ADDR_W-1:0] w_side_nxt;
    logic [SLOT_W-1:0] w_slot_nxt;

    btn_edge_det u_right_edge (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.right),
        .o_pulse (w_right_edge)
    );

    btn_edge_det u_left_edge (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.left),
        .o_pulse (w_left_edge)
    );

    always_comb begin
        w_side_nxt = r_side + ADDR_W'(1);
        w_slot_nxt = (r_slot == c_SLOT_LAST) ? '0 : r_slot + SLOT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_slot     <= '0;
            r_faddr    <= '0;
            r_side     <= c_NULL;
            r_iceil    <= c_NULL;
            r_fceil    <= c_NULL;
            r_fside    <= c_NULL;
            r_sys_en   <= 1'b0;
            r_buf_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_state  <= c_ST_COMPUTE;
                        r_cnt    <= '0;
                        r_slot   <= '0;
                        r_faddr  <= c_FILT_BASE - ADDR_W'(1);
                        r_side   <= '0;
                        r_iceil  <= c_CEIL_OFF;
                        r_fceil  <= c_FILT_BASE;
                        r_fside  <= c_NULL;
                        r_sys_en <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                c_ST_COMPUTE: begin
                    // Side array sees the ceiling word one cycle later.
                    r_fside <= r_fceil;
                    if (r_cnt == c_STREAM_LAST) begin
                        r_state <= c_ST_DRAIN;
                        r_cnt   <= '0;
                        r_side  <= c_NULL;
                        r_iceil <= c_NULL;
                        r_fceil <= c_NULL;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_side  <= w_side_nxt;
                        r_iceil <= w_side_nxt + c_CEIL_OFF;
                        r_slot  <= w_slot_nxt;
                        if (w_slot_nxt == c_SLOT_LAST) begin
                            r_fceil <= c_NULL;
                        end else begin
                            r_fceil <= r_faddr;
                            r_faddr <= r_faddr - ADDR_W'(1);
                        end
                    end
                end
                c_ST_DRAIN: begin
                    r_fside <= c_NULL;
                    if (r_cnt == c_DRAIN_LAST) begin
                        r_state <= c_ST_HOLD;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_ST_HOLD: begin
                    if (bus.toggle) begin
                        r_state    <= c_ST_DISPLAY;
                        r_buf_addr <= '0;
                    end
                end
                c_ST_DISPLAY: begin
                    if (!bus.toggle) begin
                        r_state <= c_ST_HOLD;
                    end else if (w_right_edge) begin
                        if (r_buf_addr == c_BUF_LAST) begin
                            r_state    <= c_ST_IDLE;
                            r_buf_addr <= '0;
                            r_sys_en   <= 1'b0;
                            r_done     <= 1'b0;
                        end else begin
                            r_buf_addr <= r_buf_addr + BUF_AW'(1);
                        end
                    end else if (w_left_edge) begin
                        if (r_buf_addr != '0) r_buf_addr <= r_buf_addr - BUF_AW'(1);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.input_side_addr     = r_side;
    assign bus.input_ceiling_addr  = r_iceil;
    assign bus.filter_ceiling_addr = r_fceil;
    assign bus.filter_side_addr    = r_fside;
    assign bus.sys_en              = r_sys_en;
    assign bus.buffer_read_addr    = r_buf_addr;
    assign bus.busy                = r_busy;
    assign bus.done                = r_done;
endmodule
`default_nettype wire
